csea16_resp_checker: RTL

//  Synthesizable response checker for the 16-bit carry-select adder (csea16).
//  It sits on the result side of the adder under test. It queues each applied

---
 rtl/csea16_resp_checker.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/csea16_resp_checker.sv
// Response checker for the csea16 adder: queues applied operands, pairs them in
// order with adder results, compares against A+B+Cin and tallies a run of NVEC.
module csea16_resp_checker #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NVEC  = 256,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   Start,
    input  logic                   Op_valid,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic                   Cin,
    input  logic                   Res_valid,
    input  logic [WIDTH-1:0]       Sum,
    input  logic                   Cout,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Pass,
    output logic [15:0]            Err_count,
    output logic [15:0]            Vec_count,
    output logic                   Proto_err,
    output logic [2*WIDTH+WIDTH+2:0] Fail_vec
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned OPW = 2*WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [OPW-1:0]   r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    logic             w_run;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_orphan;
    logic             w_ovf;
    logic [OPW-1:0]   w_head;
    logic [WIDTH-1:0] w_hA;
    logic [WIDTH-1:0] w_hB;
    logic             w_hCin;
    logic [WIDTH:0]   w_golden;
    logic             w_mismatch;
    logic             w_err_inc;
    logic [15:0]      w_err_next;
    logic [15:0]      w_vec_next;
    logic             w_proto_next;
    logic             w_last;

    assign w_run   = (r_state == S_RUN);
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    // A pop frees a slot in the same cycle, so a push onto a full FIFO survives it.
    assign w_pop    = w_run && Res_valid && !w_empty;
    assign w_push   = w_run && Op_valid && (!w_full || w_pop);
    assign w_orphan = w_run && Res_valid && w_empty;
    assign w_ovf    = w_run && Op_valid && w_full && !w_pop;

    assign w_head = r_mem[r_rptr[AW-1:0]];
    assign w_hA   = w_head[OPW-1 -: WIDTH];
    assign w_hB   = w_head[WIDTH:1];
    assign w_hCin = w_head[0];

    assign w_golden   = {1'b0, w_hA} + {1'b0, w_hB} + {{WIDTH{1'b0}}, w_hCin};
    assign w_mismatch = (w_golden != {Cout, Sum});

    assign w_err_inc    = w_pop && w_mismatch && (Err_count != '1);
    assign w_err_next   = Err_count + {15'd0, w_err_inc};
    assign w_vec_next   = Vec_count + 16'd1;
    assign w_proto_next = Proto_err | w_orphan | w_ovf;
    assign w_last       = w_pop && (w_vec_next == 16'(NVEC));

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= {A, B, Cin};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state   <= S_IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
            Pass      <= 1'b0;
            Err_count <= '0;
            Vec_count <= '0;
            Proto_err <= 1'b0;
            Fail_vec  <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (Start) begin
                        r_state   <= S_RUN;
                        r_wptr    <= '0;
                        r_rptr    <= '0;
                        Busy      <= 1'b1;
                        Done      <= 1'b0;
                        Pass      <= 1'b0;
                        Err_count <= '0;
                        Vec_count <= '0;
                        Proto_err <= 1'b0;
                        Fail_vec  <= '0;
                    end
                end
                S_RUN: begin
                    Proto_err <= w_proto_next;
                    if (w_push) begin
                        r_wptr <= r_wptr + 1'b1;
                    end
                    if (w_pop) begin
                        r_rptr    <= r_rptr + 1'b1;
                        Vec_count <= w_vec_next;
                        Err_count <= w_err_next;
                        if (w_mismatch && (Err_count == '0)) begin
                            Fail_vec <= {1'b0, w_hA, w_hB, w_hCin, Cout, Sum};
                        end
                    end
                    // Leftover operands are discarded by zeroing both pointers.
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_wptr  <= '0;
                        r_rptr  <= '0;
                        Busy    <= 1'b0;
                        Done    <= 1'b1;
                        Pass    <= (w_err_next == '0) && !w_proto_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
